// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the down-counter width helper.
package md_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Counter must hold LAT-1 for the longer class; never narrower than one bit.
    function automatic int unsigned md_cnt_width(input int unsigned mul_lat,
                                                 input int unsigned div_lat);
        int unsigned m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: computes the committed {HI,LO} for a latched op and
// flags divide-by-zero. HI/LO pass through unchanged for anything it does not own.
module md_arith
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c,
    output logic             div_zero_c
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx;
    logic [W2-1:0]    prod_s, prod_u, acc;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] b_safe, a_mag, b_mag;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi, lo};

    // Division on magnitudes; a zero divisor is replaced so no X is produced.
    assign b_zero = (b == '0);
    assign b_safe = b_zero ? WIDTH'(1) : b;
    assign a_neg  = a[WIDTH-1];
    assign b_neg  = b_safe[WIDTH-1];
    assign a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag  = b_neg ? (~b_safe + WIDTH'(1)) : b_safe;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign q_s    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    assign r_s    = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    assign q_u    = a / b_safe;
    assign r_u    = a % b_safe;

    always_comb begin
        hi_c       = hi;
        lo_c       = lo;
        div_zero_c = 1'b0;
        case (op)
            MULT:  {hi_c, lo_c} = prod_s;
            MULTU: {hi_c, lo_c} = prod_u;
            MADD:  {hi_c, lo_c} = acc + prod_s;
            MADDU: {hi_c, lo_c} = acc + prod_u;
            MSUB:  {hi_c, lo_c} = acc - prod_s;
            MSUBU: {hi_c, lo_c} = acc - prod_u;
            DIV: begin
                if (b_zero) begin
                    div_zero_c = 1'b1;
                end else begin
                    lo_c = q_s;
                    hi_c = r_s;
                end
            end
            DIVU: begin
                if (b_zero) begin
                    div_zero_c = 1'b1;
                end else begin
                    lo_c = q_u;
                    hi_c = r_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, accumulate ops and an
// abort window covering the first busy cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = md_cnt_width(MUL_LAT, DIV_LAT);

    md_state_e        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [3:0]       op_q, op_n;
    logic [WIDTH-1:0] d1_q, d1_n, d2_q, d2_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             first_q, first_n;
    logic             busy_n, done_n, div_zero_n;
    logic [WIDTH-1:0] arith_hi_c, arith_lo_c;
    logic             arith_dz_c;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op         (op_q),
        .a          (d1_q),
        .b          (d2_q),
        .hi         (hi),
        .lo         (lo),
        .hi_c       (arith_hi_c),
        .lo_c       (arith_lo_c),
        .div_zero_c (arith_dz_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            first_q  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_q     <= op_n;
            d1_q     <= d1_n;
            d2_q     <= d2_n;
            first_q  <= first_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= div_zero_n;
        end
    end

    // Next-state, latch and commit logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        op_n       = op_q;
        d1_n       = d1_q;
        d2_n       = d2_q;
        first_n    = 1'b0;
        hi_n       = hi;
        lo_n       = lo;
        done_n     = 1'b0;
        div_zero_n = 1'b0;

        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        MTHI: hi_n = d1;
                        MTLO: lo_n = d1;
                        MULT, MULTU, MADD, MADDU, MSUB, MSUBU: begin
                            op_n    = op;
                            d1_n    = d1;
                            d2_n    = d2;
                            cnt_n   = CW'(MUL_LAT - 1);
                            first_n = 1'b1;
                            state_n = RUN;
                        end
                        DIV, DIVU: begin
                            op_n    = op;
                            d1_n    = d1;
                            d2_n    = d2;
                            cnt_n   = CW'(DIV_LAT - 1);
                            first_n = 1'b1;
                            state_n = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // The issuer is in M only during the first RUN cycle; abort wins over commit.
                if (first_q && cancel) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    hi_n       = arith_hi_c;
                    lo_n       = arith_lo_c;
                    done_n     = 1'b1;
                    div_zero_n = arith_dz_c;
                    state_n    = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN);
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at default parameters with hand-computed results.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        cancel;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int n;

    md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .d1       (d1),
        .d2       (d2),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start  = 1'b1;
        op     = o;
        d1     = a;
        d2     = b;
        cancel = c;
        step();
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    // Counts busy cycles from now until busy drops, bounded.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; d1 = '0; d2 = '0;
        step(); step();
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_flags", 64'({busy, done, div_zero}), 64'h0);
        reset = 1'b0;
        step();

        // MULT -2 * 3
        issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_busy1", 64'(busy), 64'h1);
        chk("mult_done_early", 64'(done), 64'h0);
        wait_idle(n);
        chk("mult_lat", 64'(n), 64'd5);
        chk("mult_done", 64'(done), 64'h1);
        chk("mult_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFA);

        // MULTU issued back-to-back in the cycle busy fell
        issue(MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu_b2b_busy", 64'(busy), 64'h1);
        chk("multu_done_pulse", 64'(done), 64'h0);
        wait_idle(n);
        chk("multu_lat", 64'(n), 64'd5);
        chk("multu_hilo", {32'(hi), 32'(lo)}, 64'h0000_0002_FFFF_FFFA);
        step();
        chk("done_clears", 64'(done), 64'h0);

        // DIV -7 / 2
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("div_lat", 64'(n), 64'd10);
        chk("div_done", 64'({done, div_zero}), 64'h2);
        chk("div_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        step();

        // DIV most-negative / -1
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        chk("div_ovf_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);
        step();

        // MTHI / MTLO preload then MADD / MSUBU
        issue(MTHI, 32'd0, 32'd0, 1'b0);
        chk("mthi_nobusy", 64'(busy), 64'h0);
        chk("mthi_hi", 64'(hi), 64'h0);
        issue(MTLO, 32'd5, 32'd0, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'h5);
        issue(MADD, 32'd3, 32'd4, 1'b0);
        wait_idle(n);
        chk("madd_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_0011);
        step();
        issue(MSUBU, 32'd1, 32'd18, 1'b0);
        wait_idle(n);
        chk("msubu_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // MADD cancelled in the first busy cycle
        issue(MADD, 32'd2, 32'd2, 1'b0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("abort_no_late_done", 64'(done), 64'h0);

        // MADD with cancel in the third busy cycle still commits
        issue(MADD, 32'd2, 32'd2, 1'b0);
        step(); step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        wait_idle(n);
        chk("late_cancel_lat", 64'(n + 3), 64'd5);
        chk("late_cancel_done", 64'(done), 64'h1);
        chk("late_cancel_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_0003);
        step();

        // DIVU by zero leaves HI/LO intact
        issue(MTHI, 32'h11, 32'd0, 1'b0);
        issue(MTLO, 32'h22, 32'd0, 1'b0);
        issue(DIVU, 32'd5, 32'd0, 1'b0);
        wait_idle(n);
        chk("divz_lat", 64'(n), 64'd10);
        chk("divz_flags", 64'({done, div_zero}), 64'h3);
        chk("divz_hilo", {32'(hi), 32'(lo)}, 64'h0000_0011_0000_0022);
        step();
        chk("divz_flag_clears", 64'(div_zero), 64'h0);

        // start together with cancel suppresses MTLO
        issue(MTLO, 32'h99, 32'd0, 1'b1);
        chk("mtlo_cancel_lo", 64'(lo), 64'h22);
        chk("mtlo_cancel_busy", 64'(busy), 64'h0);

        // asynchronous reset in the middle of a divide
        issue(DIV, 32'd100, 32'd7, 1'b0);
        step(); step(); step();
        reset = 1'b1;
        #1;
        chk("arst_hilo", {32'(hi), 32'(lo)}, 64'h0);
        chk("arst_flags", 64'({busy, done, div_zero}), 64'h0);
        #1;
        reset = 1'b0;
        repeat (12) step();
        chk("arst_no_commit", {32'(hi), 32'(lo), 32'({busy, done})}, 96'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
